// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream boot loader.
// The optional trailing checksum byte is enabled by BOOT_LOADER_CHECKSUM_EN.
package boot_loader_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int INSTR_W     = 16;
  localparam int BYTE_W      = 8;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    INS_HI,
    INS_LO,
    CSUM,
    DONE,
    ERR
  } state_t;

  // An image may fill the whole instruction memory but no more.
  function automatic logic len_too_big(input logic [15:0] n, input int addr_w);
    return 32'(n) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/boot_loader_fsm.sv
// Loader sequencing: stream state, remaining-word down-counter, write index and byte assembly.
// BOOT_LOADER_CHECKSUM_EN adds the CSUM state and the running XOR of the stream.
//
// state         | meaning
// LEN_LO/LEN_HI | length bytes, little endian
// INS_HI/INS_LO | instruction bytes; the low byte completes a word
// CSUM          | trailing checksum byte (checksum build only)
// DONE/ERR      | image loaded / load failed; wait for reload
module boot_loader_fsm
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               reload,
  output logic               rx_ready,
  output logic               word_fire,
  output logic [INSTR_W-1:0] word_data,
  output logic [ADDR_W-1:0]  word_index,
  output logic               word_last,
  output logic               finish,
  output logic               fail,
  output logic               restart
);

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(1);

  state_t            state;
  logic [BYTE_W-1:0] len_lo;
  logic [BYTE_W-1:0] hi_byte;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] index;
  logic [15:0]       len_word;
  logic              xfer;
  logic              len_big;
  logic              len_zero;

  assign xfer       = rx_valid && rx_ready;
  assign len_word   = {rx_data, len_lo};
  assign len_big    = len_too_big(len_word, ADDR_W);
  assign len_zero   = (len_word == 16'd0);
  assign word_fire  = xfer && (state == INS_LO);
  assign word_data  = {hi_byte, rx_data};
  assign word_index = index;
  assign restart    = reload && ((state == DONE) || (state == ERR));

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t TAIL       = CSUM;
  localparam logic   TAIL_READY = 1'b1;

  logic [BYTE_W-1:0] csum;
  logic              csum_fire;

  assign csum_fire = xfer && (state == CSUM);
  assign word_last = 1'b0;
  assign finish    = csum_fire && (rx_data == csum);
  assign fail      = (xfer && (state == LEN_HI) && len_big) || (csum_fire && (rx_data != csum));

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else if (xfer && (state == LEN_LO)) begin
      csum <= rx_data;
    end else if (xfer && (state != CSUM)) begin
      csum <= csum ^ rx_data;
    end
  end
`else
  localparam state_t TAIL       = DONE;
  localparam logic   TAIL_READY = 1'b0;

  assign word_last = (remaining == LAST_WORD);
  assign finish    = xfer && (state == LEN_HI) && len_zero;
  assign fail      = xfer && (state == LEN_HI) && len_big;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LEN_LO;
      rx_ready  <= 1'b0;
      len_lo    <= '0;
      hi_byte   <= '0;
      remaining <= '0;
      index     <= '0;
    end else begin
      case (state)
        LEN_LO: begin
          rx_ready <= 1'b1;
          index    <= '0;
          if (xfer) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: if (xfer) begin
          if (len_big) begin
            state    <= ERR;
            rx_ready <= 1'b0;
          end else if (len_zero) begin
            state    <= TAIL;
            rx_ready <= TAIL_READY;
          end else begin
            state     <= INS_HI;
            remaining <= len_word[ADDR_W:0];
          end
        end
        INS_HI: if (xfer) begin
          hi_byte <= rx_data;
          state   <= INS_LO;
        end
        INS_LO: if (xfer) begin
          index     <= index + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == LAST_WORD) begin
            state    <= TAIL;
            rx_ready <= TAIL_READY;
          end else begin
            state <= INS_HI;
          end
        end
        CSUM: if (xfer) begin
          rx_ready <= 1'b0;
          state    <= fail ? ERR : DONE;
        end
        DONE, ERR: if (reload) begin
          state    <= LEN_LO;
          rx_ready <= 1'b1;
        end
        default: begin
          state    <= ERR;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Boot loader top: registered instruction-memory write port, core reset and status flags.
// Build with BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int LOAD_BASE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_data,
  output logic               rx_ready,
  input  logic               reload,
  output logic               imem_wr_en,
  output logic [ADDR_W-1:0]  imem_wr_addr,
  output logic [INSTR_W-1:0] imem_wr_data,
  output logic               core_reset,
  output logic               done,
  output logic               err
);

  logic               word_fire;
  logic [INSTR_W-1:0] word_data;
  logic [ADDR_W-1:0]  word_index;
  logic               word_last;
  logic               finish;
  logic               fail;
  logic               restart;
  logic               wr_last;

  boot_loader_fsm #(
    .ADDR_W (ADDR_W)
  ) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .reload     (reload),
    .rx_ready   (rx_ready),
    .word_fire  (word_fire),
    .word_data  (word_data),
    .word_index (word_index),
    .word_last  (word_last),
    .finish     (finish),
    .fail       (fail),
    .restart    (restart)
  );

  // Completion after the last word is reported one cycle after its write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      wr_last      <= 1'b0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      imem_wr_en <= word_fire;
      wr_last    <= word_fire && word_last;
      if (word_fire) begin
        imem_wr_addr <= ADDR_W'(LOAD_BASE) + word_index;
        imem_wr_data <= word_data;
      end
      if (restart) begin
        done       <= 1'b0;
        err        <= 1'b0;
        core_reset <= 1'b1;
      end else if (fail) begin
        err        <= 1'b1;
        core_reset <= 1'b1;
      end else if (finish || (imem_wr_en && wr_last)) begin
        done       <= 1'b1;
        core_reset <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: randomized images against a queue-based reference model.
// Also exercises the checksum byte when built with BOOT_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int LOAD_BASE = 0;
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [15:0]       imem_wr_data;
  logic              core_reset;
  logic              done;
  logic              err;

  boot_loader #(
    .ADDR_W    (ADDR_W),
    .LOAD_BASE (LOAD_BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .imem_wr_en   (imem_wr_en),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .core_reset   (core_reset),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus and reference model
  logic [7:0]        stim_q[$];
  logic [15:0]       word_q[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [15:0]       exp_data[$];

  // observed writes
  logic [ADDR_W-1:0] wa_q[$];
  logic [15:0]       wd_q[$];
  int                wb_q[$];
  int cyc = 0;
  int nbytes, last_xfer_cyc, done_cyc;

  // A transfer seen here completes on the next rising edge; writes are logged before counting it.
  always @(negedge clk) begin
    cyc++;
    if (imem_wr_en) begin
      wa_q.push_back(imem_wr_addr);
      wd_q.push_back(imem_wr_data);
      wb_q.push_back(nbytes);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (!reset && rx_valid && rx_ready) begin
      nbytes++;
      last_xfer_cyc = cyc;
    end
  end

  task automatic clear_monitor();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
    nbytes = 0; last_xfer_cyc = -1; done_cyc = -1;
  endtask

  task automatic build_image(input int len);
    logic [7:0]  x;
    logic [15:0] w;
    stim_q.delete(); exp_addr.delete(); exp_data.delete();
    stim_q.push_back(8'(len));
    stim_q.push_back(8'(len >> 8));
    if (len <= (1 << ADDR_W)) begin
      for (int i = 0; i < word_q.size(); i++) begin
        w = word_q[i];
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[7:0]);
        exp_addr.push_back(ADDR_W'((LOAD_BASE + i) % (1 << ADDR_W)));
        exp_data.push_back(w);
      end
      if (CSUM_EN) begin
        x = 8'h00;
        foreach (stim_q[i]) x = x ^ stim_q[i];
        stim_q.push_back(x);
      end
    end
  endtask

  task automatic drive_stream(input int gap_pct, input bit reload_noise);
    int i = 0;
    int t = 0;
    while (i < stim_q.size() && t < 20000) begin
      reload = reload_noise && ($urandom_range(7) == 0);
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = stim_q[i];
      end
      @(negedge clk);
      if (rx_valid && rx_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0;
    reload   = 1'b0;
    checks++;
    if (i != stim_q.size()) begin
      errors++;
      $display("FAIL stream_timeout sent %0d bytes want %0d", i, stim_q.size());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reload(input string name);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL %s_reload got ready=%b done=%b err=%b core_reset=%b want 1 0 0 1",
               name, rx_ready, done, err, core_reset);
    end
    @(posedge clk); #1;
  endtask

  // Drives the current stim_q and compares writes, strobe timing and completion with the model.
  task automatic run_and_check_image(input string name, input int gap_pct, input bit noise);
    int off;
    clear_monitor();
    drive_stream(gap_pct, noise);
    idle(4);
    @(negedge clk);
    checks++;
    if (wa_q.size() !== exp_addr.size()) begin
      errors++;
      $display("FAIL %s_count got %0d writes want %0d", name, wa_q.size(), exp_addr.size());
    end
    for (int k = 0; k < wa_q.size() && k < exp_addr.size(); k++) begin
      checks++;
      if (wa_q[k] !== exp_addr[k] || wd_q[k] !== exp_data[k] || wb_q[k] !== 2 + 2 * (k + 1)) begin
        errors++;
        $display("FAIL %s_write%0d got %h@%h after %0d bytes want %h@%h after %0d bytes",
                 name, k, wd_q[k], wa_q[k], wb_q[k], exp_data[k], exp_addr[k], 2 + 2 * (k + 1));
      end
    end
    off = (CSUM_EN || exp_addr.size() == 0) ? 1 : 2;
    checks++;
    if (done_cyc !== last_xfer_cyc + off) begin
      errors++;
      $display("FAIL %s_done_time got cycle %0d want %0d", name, done_cyc, last_xfer_cyc + off);
    end
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || core_reset !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_final got done=%b err=%b core_reset=%b ready=%b want 1 0 0 0",
               name, done, err, core_reset, rx_ready);
    end
    @(posedge clk); #1;
    pulse_reload(name);
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
    clear_monitor();
    idle(3);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || imem_wr_en !== 1'b0 || imem_wr_addr !== '0 || imem_wr_data !== 16'h0 ||
        core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got ready=%b wr=%b addr=%h data=%h core_reset=%b done=%b err=%b",
               rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data, core_reset, done, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got ready=%b core_reset=%b want 1 1", rx_ready, core_reset);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_n3();
    word_q = {16'h1234, 16'hABCD, 16'h0001};
    build_image(3);
    run_and_check_image("n3", 0, 1'b0);
  endtask

  task automatic test_n3_gapped();
    for (int r = 0; r < 3; r++) begin
      word_q = {16'h1234, 16'hABCD, 16'h0001};
      build_image(3);
      run_and_check_image("n3_gapped", 50, 1'b0);
    end
  endtask

  task automatic test_zero();
    word_q.delete();
    build_image(0);
    run_and_check_image("zero", 0, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      word_q.delete();
      for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
      build_image(n);
      run_and_check_image("random", $urandom_range(0, 60), 1'b1);
    end
  endtask

  task automatic test_max_len();
    word_q.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) word_q.push_back(16'($urandom));
    build_image(1 << ADDR_W);
    run_and_check_image("max_len", 10, 1'b0);
  endtask

  task automatic test_len_error(input int len);
    word_q.delete();
    build_image(len);
    clear_monitor();
    drive_stream(0, 1'b0);
    idle(4);
    @(negedge clk);
    checks++;
    if (wa_q.size() !== 0) begin
      errors++;
      $display("FAIL len_error_writes got %0d writes want 0 (len %0h)", wa_q.size(), len);
    end
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_error_flags got err=%b done=%b core_reset=%b ready=%b want 1 0 1 0",
               err, done, core_reset, rx_ready);
    end
    @(posedge clk); #1;
    pulse_reload("len_error");
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] full_q[$];
    word_q = {16'h1234, 16'hABCD, 16'h0001};
    build_image(3);
    full_q = stim_q;
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back(full_q[i]);
    clear_monitor();
    drive_stream(0, 1'b0);
    rx_valid = 1'b1;
    rx_data  = full_q[5];
    reset    = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload_collision got ready=%b want 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || imem_wr_en !== 1'b0 || imem_wr_addr !== '0 || imem_wr_data !== 16'h0 ||
        core_reset !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset_values got ready=%b wr=%b addr=%h data=%h core_reset=%b done=%b err=%b",
               rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data, core_reset, done, err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    checks++;
    if (wa_q.size() !== 1) begin
      errors++;
      $display("FAIL midload_writes got %0d writes want 1", wa_q.size());
    end
    stim_q = full_q;
    run_and_check_image("after_midload", 0, 1'b0);
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum_bad();
    word_q = {16'h1234};
    build_image(1);
    stim_q[stim_q.size() - 1] = 8'h00;
    clear_monitor();
    drive_stream(0, 1'b0);
    idle(4);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL csum_bad_flags got err=%b done=%b core_reset=%b want 1 0 1", err, done, core_reset);
    end
    checks++;
    if (wa_q.size() !== 1 || wd_q[0] !== 16'h1234 || wa_q[0] !== '0) begin
      errors++;
      $display("FAIL csum_bad_writes got %0d writes want 1234@000", wa_q.size());
    end
    @(posedge clk); #1;
    pulse_reload("csum_bad");
  endtask

  task automatic test_checksum();
    word_q = {16'h1234};
    build_image(1);
    run_and_check_image("csum_good", 0, 1'b0);
    test_checksum_bad();
  endtask
`endif

  initial begin
    test_reset();
    test_n3();
    test_zero();
    test_len_error(16'h0401);
    test_len_error((1 << ADDR_W) + 1);
    test_n3_gapped();
    test_random();
    test_reset_mid_load();
    test_max_len();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
